// File: rtl/dmac_transfer_engine.sv
// DMAC transfer engine: copies a block of words from src to dst over the shared bus,
// one read beat then one write beat per word, and raises a sticky done flag at the end.
module dmac_transfer_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int SIZE_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              op_start,
  input  logic              op_clear,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [SIZE_W-1:0] data_size,
  output logic              m_req,
  input  logic              m_grant,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_dout,
  input  logic [DATA_W-1:0] m_din,
  output logic              busy,
  output logic              done,
  output logic [SIZE_W-1:0] count
);

  typedef enum logic [1:0] {IDLE, REQ, READ, WRITE} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic [DATA_W-1:0] data_buf;
  logic [SIZE_W-1:0] count_q;
  logic              done_q;
  logic              load, capture, commit, set_done, clr_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Bus outputs are pure functions of state so a stalled beat holds them steady.
  always_comb begin
    state_next = state;
    m_req      = 1'b0;
    m_wr       = 1'b0;
    m_addr     = '0;
    m_dout     = '0;
    busy       = 1'b0;
    load       = 1'b0;
    capture    = 1'b0;
    commit     = 1'b0;
    set_done   = 1'b0;
    clr_done   = 1'b0;
    case (state)
      IDLE: begin
        if (op_clear) begin
          clr_done = 1'b1;
        end else if (op_start) begin
          if (data_size != '0) begin
            load       = 1'b1;
            clr_done   = 1'b1;
            state_next = REQ;
          end else begin
            set_done = 1'b1;
          end
        end
      end
      REQ: begin
        m_req = 1'b1;
        busy  = 1'b1;
        if (op_clear)     state_next = IDLE;
        else if (m_grant) state_next = READ;
      end
      READ: begin
        m_req  = 1'b1;
        busy   = 1'b1;
        m_addr = src_ptr;
        if (op_clear) begin
          state_next = IDLE;
        end else if (m_grant) begin
          capture    = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE: begin
        m_req  = 1'b1;
        busy   = 1'b1;
        m_wr   = 1'b1;
        m_addr = dst_ptr;
        m_dout = data_buf;
        // An abort wins over a granted write: the beat never commits.
        if (op_clear) begin
          state_next = IDLE;
        end else if (m_grant) begin
          commit = 1'b1;
          if (count_q == SIZE_W'(1)) begin
            set_done   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = READ;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_ptr  <= '0;
      dst_ptr  <= '0;
      data_buf <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      if (load) begin
        src_ptr <= src_addr;
        dst_ptr <= dst_addr;
        count_q <= data_size;
      end else if (commit) begin
        src_ptr <= src_ptr + ADDR_W'(1);
        dst_ptr <= dst_ptr + ADDR_W'(1);
        count_q <= count_q - SIZE_W'(1);
      end
      if (capture) data_buf <= m_din;
      if (clr_done)      done_q <= 1'b0;
      else if (set_done) done_q <= 1'b1;
    end
  end

  assign done  = done_q;
  assign count = count_q;

endmodule

// File: tb/tb_dmac_transfer_engine.sv
// Scoreboard bench for dmac_transfer_engine: a word-by-word copy model predicts every
// write beat, and a bus monitor pops and compares each beat as the engine issues it.
module tb_dmac_transfer_engine;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SW = 16;

  logic          clk;
  logic          reset_n;
  logic          op_start, op_clear;
  logic [AW-1:0] src_addr, dst_addr;
  logic [SW-1:0] data_size;
  logic          m_req, m_grant, m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_dout, m_din;
  logic          busy, done;
  logic [SW-1:0] count;

  dmac_transfer_engine #(.ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW)) dut (
    .clk(clk), .reset_n(reset_n), .op_start(op_start), .op_clear(op_clear),
    .src_addr(src_addr), .dst_addr(dst_addr), .data_size(data_size),
    .m_req(m_req), .m_grant(m_grant), .m_wr(m_wr), .m_addr(m_addr),
    .m_dout(m_dout), .m_din(m_din), .busy(busy), .done(done), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [DW-1:0] data;
  } beat_t;

  logic [DW-1:0] mem    [256];
  logic [DW-1:0] refmem [256];
  beat_t         exp_q  [$];
  beat_t         mon_e;
  logic [AW-1:0] last_rd;
  int            n_cmp, n_fail, wr_commits;
  logic          req_seen, rand_grant;

  assign m_din = mem[m_addr];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus memory: a write beat lands on the edge it is granted.
  always @(posedge clk) begin
    if (reset_n && m_req && m_grant && m_wr && !op_clear) begin
      mem[m_addr] = m_dout;
      wr_commits++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_grant) m_grant = ($urandom_range(3) != 0);
  end

  // Monitor: remembers the last granted read address, pairs it with the next write beat.
  always @(negedge clk) begin
    if (reset_n && m_req) req_seen = 1'b1;
    if (reset_n && m_req && m_grant) begin
      if (!m_wr) begin
        last_rd = m_addr;
      end else if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL unexpected_write_beat: got addr %0h expected no beat", m_addr);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("rd_addr", 64'(last_rd), 64'(mon_e.src));
        checkOutput("wr_addr", 64'(m_addr), 64'(mon_e.dst));
        checkOutput("wr_data", 64'(m_dout), 64'(mon_e.data));
      end
    end
  end

  task automatic load_mem();
    for (int i = 0; i < 256; i++) begin
      mem[i]    = $urandom;
      refmem[i] = mem[i];
    end
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem[a]    = d;
    refmem[a] = d;
  endtask

  // Issues a start from IDLE and predicts the block as a sequential word copy.
  task automatic applyStimulus(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [SW-1:0] n);
    beat_t b;
    @(posedge clk);
    #1;
    src_addr  = s;
    dst_addr  = d;
    data_size = n;
    op_start  = 1'b1;
    for (int k = 0; k < int'(n); k++) begin
      b.src  = s + AW'(k);
      b.dst  = d + AW'(k);
      b.data = refmem[b.src];
      refmem[b.dst] = b.data;
      exp_q.push_back(b);
    end
    @(posedge clk);
    #1;
    op_start = 1'b0;
  endtask

  // Waits for done; optionally fires stray starts that must be ignored while busy.
  task automatic wait_done(input string name, input int budget, input bit noisy);
    bit hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        hit = 1'b1;
        break;
      end
      if (noisy) begin
        op_start  = ($urandom_range(5) == 0);
        src_addr  = AW'($urandom);
        dst_addr  = AW'($urandom);
        data_size = SW'($urandom_range(0, 9));
      end
    end
    op_start = 1'b0;
    checkOutput({name, "_done_in_time"}, 64'(hit), 64'(1));
  endtask

  initial begin
    int base, mism;
    n_cmp = 0; n_fail = 0; wr_commits = 0;
    req_seen = 0; rand_grant = 0; last_rd = '0;
    reset_n = 0; op_start = 0; op_clear = 0; m_grant = 0;
    src_addr = '0; dst_addr = '0; data_size = '0;
    load_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_m_req", 64'(m_req), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_done", 64'(done), 64'(0));
    checkOutput("rst_count", 64'(count), 64'(0));
    checkOutput("rst_m_addr", 64'(m_addr), 64'(0));
    reset_n = 1;

    $display("[TB] basic copy");
    poke(8'h10, 32'hA); poke(8'h11, 32'hB); poke(8'h12, 32'hC);
    m_grant = 1;
    applyStimulus(8'h10, 8'h80, 16'd3);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checkOutput($sformatf("basic_busy_c%0d", c), 64'(busy), 64'(c <= 7));
      checkOutput($sformatf("basic_done_c%0d", c), 64'(done), 64'(c >= 8));
      checkOutput($sformatf("basic_req_c%0d", c), 64'(m_req), 64'(c <= 7));
      if (c >= 2 && c <= 7) checkOutput($sformatf("basic_wr_c%0d", c), 64'(m_wr), 64'(c % 2));
    end
    checkOutput("basic_count", 64'(count), 64'(0));
    checkOutput("basic_mem80", 64'(mem[8'h80]), 64'hA);
    checkOutput("basic_mem81", 64'(mem[8'h81]), 64'hB);
    checkOutput("basic_mem82", 64'(mem[8'h82]), 64'hC);

    $display("[TB] delayed grant");
    m_grant = 0;
    base = wr_commits;
    applyStimulus(8'h20, 8'h30, 16'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("dly_req_held", 64'(m_req), 64'(1));
      checkOutput("dly_no_wr", 64'(m_wr), 64'(0));
    end
    @(posedge clk);
    #1;
    m_grant = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("dly_done_%0d", i), 64'(done), 64'(i == 3));
    end
    checkOutput("dly_one_write", 64'(wr_commits - base), 64'(1));

    $display("[TB] wrap-around");
    applyStimulus(8'hFE, 8'hFF, 16'd3);
    wait_done("wrap", 40, 1'b0);
    checkOutput("wrap_count", 64'(count), 64'(0));
    checkOutput("wrap_q_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] zero size and start+clear");
    req_seen = 0;
    applyStimulus(8'h33, 8'h44, 16'd0);
    @(negedge clk);
    checkOutput("zero_done", 64'(done), 64'(1));
    repeat (4) @(negedge clk);
    checkOutput("zero_no_req", 64'(req_seen), 64'(0));
    @(posedge clk);
    #1;
    data_size = 16'd5; op_start = 1; op_clear = 1;
    @(posedge clk);
    #1;
    op_start = 0; op_clear = 0;
    @(negedge clk);
    checkOutput("clr_done", 64'(done), 64'(0));
    checkOutput("clr_busy", 64'(busy), 64'(0));
    checkOutput("clr_req", 64'(m_req), 64'(0));

    $display("[TB] abort");
    base = wr_commits;
    applyStimulus(8'h40, 8'h50, 16'd8);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (wr_commits - base == 2) break;
    end
    op_clear = 1;
    @(posedge clk);
    #1;
    op_clear = 0;
    @(negedge clk);
    checkOutput("abort_req", 64'(m_req), 64'(0));
    checkOutput("abort_busy", 64'(busy), 64'(0));
    checkOutput("abort_count", 64'(count), 64'(6));
    checkOutput("abort_done", 64'(done), 64'(0));
    checkOutput("abort_pending", 64'(exp_q.size()), 64'(6));
    exp_q.delete();
    applyStimulus(8'h60, 8'h70, 16'd2);
    wait_done("after_abort", 40, 1'b0);
    checkOutput("after_abort_count", 64'(count), 64'(0));

    $display("[TB] reset mid-transfer");
    applyStimulus(8'h90, 8'hA0, 16'd4);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_wr) break;
    end
    #2;
    base = wr_commits;
    reset_n = 0;
    #1;
    checkOutput("arst_req", 64'(m_req), 64'(0));
    checkOutput("arst_wr", 64'(m_wr), 64'(0));
    checkOutput("arst_busy", 64'(busy), 64'(0));
    checkOutput("arst_addr", 64'(m_addr), 64'(0));
    checkOutput("arst_dout", 64'(m_dout), 64'(0));
    checkOutput("arst_count", 64'(count), 64'(0));
    repeat (3) @(negedge clk);
    reset_n = 1;
    exp_q.delete();
    repeat (4) @(negedge clk);
    checkOutput("arst_idle", 64'(m_req), 64'(0));
    checkOutput("arst_no_write", 64'(wr_commits - base), 64'(0));

    $display("[TB] randomized transfers");
    load_mem();
    rand_grant = 1;
    for (int t = 0; t < 25; t++) begin
      applyStimulus(AW'($urandom), AW'($urandom), SW'($urandom_range(1, 10)));
      wait_done($sformatf("rand%0d", t), 200, 1'b1);
      @(negedge clk);
      checkOutput("rand_count", 64'(count), 64'(0));
      checkOutput("rand_busy", 64'(busy), 64'(0));
      checkOutput("rand_q_empty", 64'(exp_q.size()), 64'(0));
    end
    rand_grant = 0;
    mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== refmem[i]) mism++;
    checkOutput("mem_image", 64'(mism), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
